// File: rtl/restoring_divider.sv
// restoring_divider -- 8-bit by 4-bit unsigned restoring divider.
//
// A three-state FSM (IDLE -> CALC -> DONE -> IDLE). CALC retires one quotient
// bit per clock, so a division takes 8 CALC cycles. A zero divisor skips CALC
// and reports quotient 8'hFF, remainder 0 and div_by_zero.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a division (only looked at in IDLE)
//   dividend     8-bit unsigned dividend, captured on accept
//   divisor      4-bit unsigned divisor, captured on accept
//   quotient     registered quotient, held until the next completed division
//   remainder    registered remainder, held until the next completed division
//   busy         high in CALC and DONE
//   done         one-cycle pulse while in DONE
//   div_by_zero  registered: last accepted divisor was zero
module restoring_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] rem_q, rem_d;        // 5 bits: shifted partial remainder can reach 29
  logic [7:0] dvd_q, dvd_d;        // dividend, shifted out MSB first
  logic [3:0] dvs_q, dvs_d;
  logic [7:0] quo_sh_q, quo_sh_d;  // quotient under construction
  logic [7:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;

  logic [4:0] rem_shift;
  logic       fits;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_sh_d    = quo_sh_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    rem_shift = {rem_q[3:0], dvd_q[7]};
    fits      = (rem_shift >= {1'b0, dvs_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d    = dividend;
          dvs_d    = divisor;
          rem_d    = 5'd0;
          cnt_d    = 3'd0;
          quo_sh_d = 8'd0;
          if (divisor == 4'd0) begin
            // Results are published immediately; DONE only raises the pulse.
            state_d     = DONE;
            quotient_d  = 8'hFF;
            remainder_d = 4'h0;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d    = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
        dvd_d    = {dvd_q[6:0], 1'b0};
        quo_sh_d = {quo_sh_q[6:0], fits};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Last step: publish this step's values directly so outputs
          // change exactly once, on entry to DONE.
          state_d     = DONE;
          quotient_d  = quo_sh_d;
          remainder_d = rem_d[3:0];
          dbz_d       = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rem_q       <= 5'd0;
      dvd_q       <= 8'd0;
      dvs_q       <= 4'd0;
      quo_sh_q    <= 8'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 4'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_sh_q    <= quo_sh_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The module SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-003 The module SHALL have the port `start`, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-004 The module SHALL have the port `dividend`, input, 8 bits: unsigned dividend; captured when `start` is accepted.
REQ-005 The module SHALL have the port `divisor`, input, 4 bits: unsigned divisor; captured when `start` is accepted.
REQ-006 The module SHALL have the port `quotient`, output, 8 bits: registered unsigned quotient.
REQ-007 The module SHALL have the port `remainder`, output, 4 bits: registered unsigned remainder.
REQ-008 The module SHALL have the port `busy`, output, 1 bit: high while in CALC or DONE.
REQ-009 The module SHALL have the port `done`, output, 1 bit: single-cycle pulse that marks results valid.
REQ-010 The module SHALL have the port `div_by_zero`, output, 1 bit: registered flag; high when the last accepted divisor was 0.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-012 IDLE SHALL accept `start`=1 at a rising edge (edge k), latching `dividend` and `divisor` and clearing the 5-bit partial remainder and the 3-bit step counter.
REQ-013 On acceptance with a nonzero divisor, the FSM SHALL go IDLE->CALC at edge k.
REQ-014 On acceptance with divisor = 0, the FSM SHALL go IDLE->DONE at edge k and perform no iterations.
REQ-015 Each CALC edge SHALL perform one restoring step, in this order:
- form the 5-bit value rem = {rem[3:0], dividend_shift[7]};
- shift dividend_shift left by one;
- if rem >= {1'b0,divisor}, subtract divisor and shift in a quotient bit of 1;
- otherwise keep rem and shift in a quotient bit of 0.
REQ-016 CALC SHALL run exactly 8 steps, on edges k+1 through k+8; at edge k+8 the FSM SHALL go CALC->DONE and register `quotient` and `remainder` (rem[3:0]).
REQ-017 `done` SHALL be high exactly while in DONE, which lasts one cycle: the cycle after edge k+8 for a normal division, or the cycle after edge k for divide-by-zero.
REQ-018 DONE SHALL go to IDLE unconditionally on the next edge.
REQ-019 Divide-by-zero SHALL produce `quotient`=8'hFF, `remainder`=4'h0 and `div_by_zero`=1.
REQ-020 Every nonzero-divisor result SHALL clear `div_by_zero` to 0.
REQ-021 `quotient`, `remainder` and `div_by_zero` SHALL hold their values from the DONE transition until the next completed division or reset.
REQ-022 The output registers SHALL not change during CALC; intermediate values SHALL live only in internal registers.
REQ-023 `start` asserted in CALC or DONE SHALL be ignored and never queued.
REQ-024 Changes to `dividend` or `divisor` after acceptance SHALL not affect the result in progress.
REQ-025 `start` held high continuously SHALL begin a new division on the first edge the FSM is in IDLE, giving back-to-back throughput of one result per 10 cycles.
REQ-026 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every divisor in 1..15.
REQ-027 Arithmetic SHALL be unsigned; the partial remainder SHALL be 5 bits wide so that the comparison and subtraction never overflow.

Reset
REQ-028 Asserting `rst_n`=0 SHALL, without waiting for `clk`, force the state to IDLE and clear the step counter and all internal datapath registers to 0.
REQ-029 Reset SHALL set all outputs to 0: `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_by_zero`=0.
REQ-030 Reset asserted mid-CALC SHALL abandon the division, with no `done` pulse afterwards.
REQ-031 After reset is released, the first rising edge with `start`=1 SHALL be accepted normally.

Verification
REQ-032 The bench SHALL cover: dividend=200, divisor=7, `start` pulse -> `done` pulse exactly 9 edges after acceptance; quotient=28, remainder=4, div_by_zero=0.
REQ-033 The bench SHALL cover: dividend=255, divisor=15 -> quotient=17, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-034 The bench SHALL cover: dividend=100, divisor=0 -> `done` in the cycle after acceptance; quotient=8'hFF, remainder=0, div_by_zero=1; a following 12/4 division -> quotient=3, remainder=0, div_by_zero=0.
REQ-035 The bench SHALL cover: `start` re-pulsed with different operands during CALC of 200/7 -> ignored; result is still 28 r 4, and only one `done` pulse occurs.
REQ-036 The bench SHALL cover: `rst_n` pulsed low at step 4 of CALC -> outputs immediately 0, `busy`=0, no `done`; next 50/6 -> quotient=8, remainder=2.
REQ-037 The bench SHALL cover: an exhaustive sweep of all 256 dividends x divisors 1..15, checked against integer division and modulo.
